// File: rtl/apb_text_console.sv
// apb_text_console: character-stream text console that writes each printable
// character (with its colour attribute) into a memory-mapped text buffer over
// an APB master port, tracking a wrapping cursor and handling LF/CR/BS/FF.
// Optional feature: define APB_TEXT_CONSOLE_CLEAR_EN to make FF (0x0C) clear
// the whole screen with space characters before homing the cursor.
module apb_text_console #(
  parameter int APB_ADDR_WIDTH = 14,
  parameter int APB_DATA_WIDTH = 32,
  parameter int COLS           = 80,
  parameter int ROWS           = 30
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [7:0]                char_i,
  input  logic                      char_valid_i,
  input  logic [7:0]                color_i,
  output logic                      char_ready_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  output logic                      apb_pwrite_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i,
  output logic [$clog2(COLS)-1:0]   cursor_col_o,
  output logic [$clog2(ROWS)-1:0]   cursor_row_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

`ifdef APB_TEXT_CONSOLE_CLEAR_EN
  localparam int CELL_W = $clog2(COLS * ROWS);
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_CLEAR_SETUP, S_CLEAR_ACCESS
  } state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;
`endif

  state_t state_q, state_d;

  logic [COL_W-1:0]          col_q;
  logic [ROW_W-1:0]          row_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic                      err_q;
  logic [31:0]               cell_lin;
  logic [COL_W-1:0]          col_inc;
  logic [ROW_W-1:0]          row_inc;
  logic                      accept;
  logic                      printable;
  logic                      col_last;
`ifdef APB_TEXT_CONSOLE_CLEAR_EN
  logic [CELL_W-1:0]         idx_q;
  logic                      clear_last;
  assign clear_last = (idx_q == CELL_W'(COLS * ROWS - 1));
`endif

  assign accept    = char_valid_i && (state_q == S_IDLE);
  assign printable = (char_i >= 8'h20) && (char_i <= 8'h7E);
  assign cell_lin  = 32'(row_q) * 32'(COLS) + 32'(col_q);
  assign col_last  = (col_q == COL_W'(COLS - 1));
  assign col_inc   = col_last ? '0 : col_q + COL_W'(1);
  assign row_inc   = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);

  // Bus controls decode straight from state so an async reset drops them at once.
  assign char_ready_o  = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
`ifdef APB_TEXT_CONSOLE_CLEAR_EN
  assign apb_psel_o    = (state_q != S_IDLE);
  assign apb_penable_o = (state_q == S_ACCESS) || (state_q == S_CLEAR_ACCESS);
`else
  assign apb_psel_o    = (state_q != S_IDLE);
  assign apb_penable_o = (state_q == S_ACCESS);
`endif
  assign apb_pwrite_o  = apb_psel_o;
  assign apb_paddr_o   = paddr_q;
  assign apb_pwdata_o  = pwdata_q;
  assign cursor_col_o  = col_q;
  assign cursor_row_o  = row_q;
  assign err_o         = err_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments and an async active-low
  // reset so every flop settles from values sampled before the edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic for printable writes and (optionally) the screen clear.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && printable) state_d = S_SETUP;
`ifdef APB_TEXT_CONSOLE_CLEAR_EN
        else if (accept && char_i == 8'h0C) state_d = S_CLEAR_SETUP;
`endif
      end
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (apb_pready_i) state_d = S_IDLE;
`ifdef APB_TEXT_CONSOLE_CLEAR_EN
      S_CLEAR_SETUP:  state_d = S_CLEAR_ACCESS;
      S_CLEAR_ACCESS: if (apb_pready_i) state_d = clear_last ? S_IDLE : S_CLEAR_SETUP;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Cursor, captured APB address/data and the sticky error flag.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col_q    <= '0;
      row_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      err_q    <= 1'b0;
`ifdef APB_TEXT_CONSOLE_CLEAR_EN
      idx_q    <= '0;
`endif
    end else begin
      if (accept) begin
        if (printable) begin
          paddr_q  <= APB_ADDR_WIDTH'(cell_lin << 2);
          pwdata_q <= APB_DATA_WIDTH'({color_i, char_i});
        end else begin
          case (char_i)
            8'h0A: begin col_q <= '0; row_q <= row_inc; end
            8'h0D: col_q <= '0;
            8'h08: if (col_q != '0) col_q <= col_q - COL_W'(1);
`ifdef APB_TEXT_CONSOLE_CLEAR_EN
            8'h0C: begin
              idx_q    <= '0;
              paddr_q  <= '0;
              pwdata_q <= APB_DATA_WIDTH'({color_i, 8'h20});
            end
`else
            8'h0C: begin col_q <= '0; row_q <= '0; end
`endif
            default: ;
          endcase
        end
      end
      // A completed character write advances the cursor, even on a slave error.
      if (state_q == S_ACCESS && apb_pready_i) begin
        if (apb_pslverr_i) err_q <= 1'b1;
        col_q <= col_inc;
        if (col_last) row_q <= row_inc;
      end
`ifdef APB_TEXT_CONSOLE_CLEAR_EN
      if (state_q == S_CLEAR_ACCESS && apb_pready_i) begin
        if (apb_pslverr_i) err_q <= 1'b1;
        if (clear_last) begin
          col_q <= '0;
          row_q <= '0;
        end else begin
          idx_q   <= idx_q + CELL_W'(1);
          paddr_q <= paddr_q + APB_ADDR_WIDTH'(4);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_apb_text_console.sv
// tb_apb_text_console: directed plus randomized character stream against a
// cursor model kept as a linear screen position with modulo wrap.
module tb_apb_text_console;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int AW   = 14;
  localparam int DW   = 32;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic [7:0]    char_i;
  logic          char_valid_i;
  logic [7:0]    color_i;
  logic          char_ready_o;
  logic [AW-1:0] apb_paddr_o;
  logic [DW-1:0] apb_pwdata_o;
  logic          apb_pwrite_o;
  logic          apb_psel_o;
  logic          apb_penable_o;
  logic          apb_pready_i;
  logic          apb_pslverr_i;
  logic [6:0]    cursor_col_o;
  logic [4:0]    cursor_row_o;
  logic          busy_o;
  logic          err_o;

  apb_text_console #(
    .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .COLS(COLS), .ROWS(ROWS)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .char_i(char_i), .char_valid_i(char_valid_i),
    .color_i(color_i), .char_ready_o(char_ready_o), .apb_paddr_o(apb_paddr_o),
    .apb_pwdata_o(apb_pwdata_o), .apb_pwrite_o(apb_pwrite_o), .apb_psel_o(apb_psel_o),
    .apb_penable_o(apb_penable_o), .apb_pready_i(apb_pready_i),
    .apb_pslverr_i(apb_pslverr_i), .cursor_col_o(cursor_col_o),
    .cursor_row_o(cursor_row_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;
  int m_col   = 0;
  int m_row   = 0;
  bit m_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Cursor model: printable advances a linear position modulo the screen size.
  task automatic model_step(input logic [7:0] c);
    int pos;
    if (c >= 8'h20 && c <= 8'h7E) begin
      pos   = (m_row * COLS + m_col + 1) % (COLS * ROWS);
      m_row = pos / COLS;
      m_col = pos % COLS;
    end else begin
      case (c)
        8'h0A: begin m_col = 0; m_row = (m_row + 1) % ROWS; end
        8'h0D: m_col = 0;
        8'h08: if (m_col > 0) m_col = m_col - 1;
        8'h0C: begin m_col = 0; m_row = 0; end
        default: ;
      endcase
    end
  endtask

  // Send one character; n_acc = ACCESS cycles before the slave signals ready.
  task automatic send(input logic [7:0] c, input logic [7:0] color, input int n_acc,
                      input bit slverr);
    logic [31:0] exp_addr, exp_data;
    bit printable;
    @(negedge clk_i);
    check("ready_before", 32'(char_ready_o), 1);
    printable = (c >= 8'h20 && c <= 8'h7E);
    exp_addr  = 32'((m_row * COLS + m_col) * 4);
    exp_data  = {16'h0, color, c};
    char_i = c; color_i = color; char_valid_i = 1'b1;
    @(negedge clk_i);
    char_valid_i = 1'b0;
    if (printable) begin
      check("setup_ctl", 32'({apb_psel_o, apb_penable_o, apb_pwrite_o}), 32'b101);
      check("setup_addr", 32'(apb_paddr_o), exp_addr);
      check("setup_data", apb_pwdata_o, exp_data);
      check("setup_ready", 32'({busy_o, char_ready_o}), 32'b10);
      for (int k = 1; k <= n_acc; k++) begin
        @(negedge clk_i);
        check("access_ctl", 32'({apb_psel_o, apb_penable_o, apb_pwrite_o}), 32'b111);
        check("access_addr", 32'(apb_paddr_o), exp_addr);
        check("access_data", apb_pwdata_o, exp_data);
        if (k == n_acc) begin apb_pready_i = 1'b1; apb_pslverr_i = slverr; end
      end
      @(negedge clk_i);
      apb_pready_i = 1'b0; apb_pslverr_i = 1'b0;
      check("idle_ctl", 32'({apb_psel_o, apb_penable_o, busy_o}), 0);
      m_err = m_err | slverr;
    end else begin
      check("ctl_no_psel", 32'({apb_psel_o, busy_o}), 0);
    end
    model_step(c);
    check("col", 32'(cursor_col_o), 32'(m_col));
    check("row", 32'(cursor_row_o), 32'(m_row));
    check("err", 32'(err_o), 32'(m_err));
  endtask

  task automatic apply_reset();
    rstn_i = 1'b0;
    #1;
    check("rst_ctl", 32'({apb_psel_o, apb_penable_o, apb_pwrite_o, busy_o, err_o}), 0);
    check("rst_addr", 32'(apb_paddr_o), 0);
    check("rst_cursor", 32'({cursor_col_o, cursor_row_o}), 0);
    m_col = 0; m_row = 0; m_err = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("ready_after_rst", 32'({char_ready_o, apb_psel_o}), 32'b10);
  endtask

`ifdef APB_TEXT_CONSOLE_CLEAR_EN
  task automatic clear_screen();
    int cnt = 0, bad = 0;
    logic [31:0] last = '1;
    @(negedge clk_i);
    char_i = 8'h0C; color_i = 8'h07; char_valid_i = 1'b1; apb_pready_i = 1'b1;
    @(negedge clk_i);
    char_valid_i = 1'b0;
    for (int cyc = 0; cyc < 10000 && busy_o; cyc++) begin
      if (char_ready_o) bad++;
      if (apb_psel_o && apb_penable_o) begin
        if (apb_pwdata_o !== 32'h0000_0720) bad++;
        if (32'(apb_paddr_o) !== 32'(cnt * 4)) bad++;
        last = 32'(apb_paddr_o);
        cnt++;
      end
      @(negedge clk_i);
    end
    apb_pready_i = 1'b0;
    m_col = 0; m_row = 0;
    check("clear_done", 32'({busy_o, char_ready_o}), 32'b01);
    check("clear_count", 32'(cnt), 2400);
    check("clear_bad", 32'(bad), 0);
    check("clear_last_addr", last, 32'h257C);
    check("clear_cursor", 32'({cursor_col_o, cursor_row_o}), 0);
  endtask
`endif

  initial begin
    logic [7:0] c;
    int r;
    rstn_i = 1'b0; char_i = '0; char_valid_i = 1'b0; color_i = '0;
    apb_pready_i = 1'b0; apb_pslverr_i = 1'b0;
    #12;
    apply_reset();

    // 'A' in colour 0x1F at the home position, slave ready immediately.
    send(8'h41, 8'h1F, 1, 1'b0);
    check("a_cursor", 32'({cursor_col_o, cursor_row_o}), 32'({7'd1, 5'd0}));

    // Move to (5,3), then LF / CR / BS all land on (0,4).
    send(8'h0D, 8'h00, 1, 1'b0);
    for (int i = 0; i < 3; i++) send(8'h0A, 8'h00, 1, 1'b0);
    for (int i = 0; i < 5; i++) send(8'h2E, 8'h02, 1, 1'b0);
    check("at_5_3", 32'({cursor_col_o, cursor_row_o}), 32'({7'd5, 5'd3}));
    send(8'h0A, 8'h00, 1, 1'b0);
    send(8'h0D, 8'h00, 1, 1'b0);
    send(8'h08, 8'h00, 1, 1'b0);
    check("ctl_0_4", 32'({cursor_col_o, cursor_row_o}), 32'({7'd0, 5'd4}));

    // Walk to (79,29) and write 'Z' in the last cell: full wrap to (0,0).
    for (int i = 0; i < 25; i++) send(8'h0A, 8'h00, 1, 1'b0);
    for (int i = 0; i < 79; i++) send(8'h2D, 8'h03, 1, 1'b0);
    check("at_79_29", 32'({cursor_col_o, cursor_row_o}), 32'({7'd79, 5'd29}));
    send(8'h5A, 8'h0E, 1, 1'b0);
    check("z_wrap", 32'({cursor_col_o, cursor_row_o}), 0);

    // Slow slave with error on the ready cycle; error stays sticky.
    send(8'h78, 8'h33, 4, 1'b1);
    check("err_set", 32'(err_o), 1);
    send(8'h79, 8'h33, 2, 1'b0);
    check("err_sticky", 32'(err_o), 1);

    // Random character stream with random latency and rare slave errors.
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) c = 8'($urandom_range(32, 126));
      else if (r == 6) c = 8'h0A;
      else if (r == 7) c = 8'h0D;
      else if (r == 8) c = 8'h08;
      else begin
        c = 8'($urandom_range(0, 255));
        if ((c >= 8'h20 && c <= 8'h7E) || c == 8'h0A || c == 8'h0D || c == 8'h08 ||
            c == 8'h0C) c = 8'h7F;
      end
      send(c, 8'($urandom), $urandom_range(1, 3), ($urandom_range(0, 15) == 0));
    end

`ifdef APB_TEXT_CONSOLE_CLEAR_EN
    send(8'h41, 8'h01, 1, 1'b0);
    clear_screen();
    send(8'h42, 8'h01, 1, 1'b0);
    // Reset in the middle of a clear: bus drops at once, no resumption.
    @(negedge clk_i);
    char_i = 8'h0C; color_i = 8'h07; char_valid_i = 1'b1; apb_pready_i = 1'b1;
    @(negedge clk_i);
    char_valid_i = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clk_i);
    if (!apb_penable_o) @(negedge clk_i);
    check("clear_in_access", 32'({apb_psel_o, apb_penable_o}), 32'b11);
    apb_pready_i = 1'b0;
    #2;
    apply_reset();
`else
    send(8'h41, 8'h01, 1, 1'b0);
    send(8'h0C, 8'h07, 1, 1'b0);
    check("ff_home", 32'({cursor_col_o, cursor_row_o}), 0);
`endif

    // Reset in the middle of a character write.
    send(8'h43, 8'h05, 1, 1'b0);
    @(negedge clk_i);
    char_i = 8'h51; color_i = 8'h05; char_valid_i = 1'b1;
    @(negedge clk_i);
    char_valid_i = 1'b0;
    @(negedge clk_i);
    check("write_in_access", 32'({apb_psel_o, apb_penable_o}), 32'b11);
    #2;
    apply_reset();
    @(negedge clk_i);
    check("no_resume", 32'({apb_psel_o, busy_o, char_ready_o}), 32'b001);
    send(8'h44, 8'h06, 1, 1'b0);
    check("post_rst_cursor", 32'({cursor_col_o, cursor_row_o}), 32'({7'd1, 5'd0}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
